cp0_unit: RTL and testbench

CP0_UNIT -- requirements
Module: cp0_unit

---
 rtl/cp0_unit_pkg.sv | 24 ++
 rtl/cp0_unit.sv | 137 +++++++++++++
 tb/tb_cp0_unit.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_unit_pkg.sv
// Shared MIPS CP0 definitions: coprocessor op encodings, register indices,
// exception codes and redirect FSM states.
package cp0_unit_pkg;

  localparam logic [1:0] CpNone  = 2'd0;
  localparam logic [1:0] CpStore = 2'd1;
  localparam logic [1:0] CpLoad  = 2'd2;
  localparam logic [1:0] CpEret  = 2'd3;

  localparam logic [4:0] RegStatus = 5'd12;
  localparam logic [4:0] RegCause  = 5'd13;
  localparam logic [4:0] RegEpc    = 5'd14;
  localparam logic [4:0] RegEbase  = 5'd25;

  localparam logic [4:0] ExcInt = 5'd0;
  localparam logic [4:0] ExcRi  = 5'd10;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StRedir  = 2'd1,
    StSettle = 2'd2
  } cp0_state_e;

endpackage

// File: rtl/cp0_unit.sv
// MIPS coprocessor 0: STATUS/CAUSE/EPC/EBASE registers, RI and interrupt entry,
// ERET return, and a one-cycle redirect followed by a settle window.
module cp0_unit
  import cp0_unit_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_000C,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  cp_oper,
  input  logic [4:0]  cp_addr,
  input  logic [31:0] cp_wdata,
  output logic [31:0] cp_rdata,
  input  logic        exc_ri,
  input  logic        irq,
  input  logic        op_valid,
  input  logic [31:0] epc_in,
  output logic        jump_en,
  output logic [31:0] jump_addr
);

  localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;

  cp0_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic        ie_q, exl_q, ip_q, irq_q;
  logic [4:0]  exc_code_q;
  logic [31:0] epc_q, ebase_q;
  logic [31:0] jump_addr_q, jump_addr_d;

  logic in_run, irq_rise, take_ri, take_eret, take_int, take_event, accept, mtc0_we;

  // Event decode: RI beats ERET beats interrupt; only RUN accepts anything.
  always_comb begin
    in_run     = (state_q == StRun);
    irq_rise   = irq & ~irq_q;
    take_ri    = in_run & op_valid & exc_ri & ~exl_q;
    take_eret  = in_run & op_valid & (cp_oper == CpEret) & ~take_ri;
    take_int   = in_run & op_valid & ip_q & ie_q & ~exl_q & (cp_oper != CpEret) & ~take_ri;
    take_event = take_ri | take_int;
    accept     = take_event | take_eret;
    mtc0_we    = in_run & op_valid & (cp_oper == CpStore) & ~accept;
    if (take_event) begin
      jump_addr_d = ebase_q;
    end else if (take_eret) begin
      jump_addr_d = epc_q;
    end else begin
      jump_addr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StRun: begin
        if (accept) state_d = StRedir;
      end
      StRedir: begin
        if (SETTLE_CYCLES == 0) begin
          state_d = StRun;
        end else begin
          state_d = StSettle;
          cnt_d   = CntW'(SETTLE_CYCLES - 1);
        end
      end
      StSettle: begin
        if (cnt_q == '0) state_d = StRun;
        else             cnt_d = cnt_q - 1'b1;
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    jump_en   = (state_q == StRedir);
    jump_addr = jump_addr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ie_q        <= 1'b0;
      exl_q       <= 1'b0;
      ip_q        <= 1'b0;
      irq_q       <= 1'b0;
      exc_code_q  <= '0;
      epc_q       <= '0;
      ebase_q     <= EXC_VECTOR;
      jump_addr_q <= '0;
    end else begin
      irq_q       <= irq;
      jump_addr_q <= jump_addr_d;
      if (take_event) begin
        epc_q      <= epc_in;
        exl_q      <= 1'b1;
        exc_code_q <= take_ri ? ExcRi : ExcInt;
      end else if (take_eret) begin
        exl_q <= 1'b0;
      end else if (mtc0_we) begin
        case (cp_addr)
          RegStatus: {exl_q, ie_q} <= cp_wdata[1:0];
          RegCause:  exc_code_q <= cp_wdata[6:2];
          RegEpc:    epc_q <= cp_wdata;
          RegEbase:  ebase_q <= cp_wdata;
          default:   ;
        endcase
      end
      // A fresh edge in the same cycle an interrupt is taken stays pending.
      if (irq_rise)      ip_q <= 1'b1;
      else if (take_int) ip_q <= 1'b0;
    end
  end

  always_comb begin
    cp_rdata = '0;
    case (cp_addr)
      RegStatus: cp_rdata = {30'b0, exl_q, ie_q};
      RegCause:  cp_rdata = {21'b0, ip_q, 3'b0, exc_code_q, 2'b0};
      RegEpc:    cp_rdata = epc_q;
      RegEbase:  cp_rdata = ebase_q;
      default:   cp_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed self-checking bench for cp0_unit.
module tb_cp0_unit;
  import cp0_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cp_oper;
  logic [4:0]  cp_addr;
  logic [31:0] cp_wdata;
  logic [31:0] cp_rdata;
  logic        exc_ri;
  logic        irq;
  logic        op_valid;
  logic [31:0] epc_in;
  logic        jump_en;
  logic [31:0] jump_addr;

  int tests = 0;
  int fails = 0;
  logic [31:0] rv;

  cp0_unit #(.EXC_VECTOR(32'h0000_000C), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .cp_oper(cp_oper), .cp_addr(cp_addr), .cp_wdata(cp_wdata),
    .cp_rdata(cp_rdata), .exc_ri(exc_ri), .irq(irq), .op_valid(op_valid), .epc_in(epc_in),
    .jump_en(jump_en), .jump_addr(jump_addr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    cp_oper = CpNone; op_valid = 1'b0; exc_ri = 1'b0; cp_wdata = '0;
  endtask

  task automatic idle(input int n);
    idle_in();
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    cp_addr = a;
    #1;
    d = cp_rdata;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    cp_oper = CpStore; cp_addr = a; cp_wdata = d; op_valid = 1'b1;
    step();
    idle_in();
  endtask

  task automatic eret_and_settle();
    cp_oper = CpEret; op_valid = 1'b1;
    step();
    idle(3);
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_in(); irq = 1'b0; epc_in = '0; cp_addr = '0;
    step(); step();
    rst = 1'b0;
    tests++; if (jump_en !== 1'b0) begin fails++; $display("FAIL reset_jump_en got %b want 0", jump_en); end
    tests++; if (jump_addr !== 32'h0) begin fails++; $display("FAIL reset_jump_addr got %h want 0", jump_addr); end
    rd(RegStatus, rv);
    tests++; if (rv !== 32'h0) begin fails++; $display("FAIL reset_status got %h want 0", rv); end
    rd(RegCause, rv);
    tests++; if (rv !== 32'h0) begin fails++; $display("FAIL reset_cause got %h want 0", rv); end
    rd(RegEbase, rv);
    tests++; if (rv !== 32'hC) begin fails++; $display("FAIL reset_ebase got %h want c", rv); end
  endtask

  task automatic test_mtc0();
    mtc0(RegStatus, 32'h3);
    rd(RegStatus, rv);
    tests++; if (rv !== 32'h3) begin fails++; $display("FAIL mfc0_status got %h want 3", rv); end
    mtc0(5'd7, 32'hFFFF_FFFF);
    rd(5'd7, rv);
    tests++; if (rv !== 32'h0) begin fails++; $display("FAIL mfc0_unimpl got %h want 0", rv); end
    mtc0(RegCause, 32'hFFFF_FFFF);
    rd(RegCause, rv);
    tests++; if (rv !== 32'h7C) begin fails++; $display("FAIL cause_ip_ro got %h want 7c", rv); end
    mtc0(RegEpc, 32'h1234_5678);
    rd(RegEpc, rv);
    tests++; if (rv !== 32'h1234_5678) begin fails++; $display("FAIL mfc0_epc got %h want 12345678", rv); end
    mtc0(RegCause, 32'h0);
    mtc0(RegStatus, 32'h0);
  endtask

  task automatic test_irq();
    mtc0(RegStatus, 32'h1);
    irq = 1'b1;
    step();
    rd(RegCause, rv);
    tests++; if (rv !== 32'h400) begin fails++; $display("FAIL irq_sets_ip got %h want 400", rv); end
    op_valid = 1'b1; epc_in = 32'h40;
    step();
    idle_in();
    tests++; if (jump_en !== 1'b1) begin fails++; $display("FAIL int_jump_en got %b want 1", jump_en); end
    tests++; if (jump_addr !== 32'hC) begin fails++; $display("FAIL int_jump_addr got %h want c", jump_addr); end
    rd(RegEpc, rv);
    tests++; if (rv !== 32'h40) begin fails++; $display("FAIL int_epc got %h want 40", rv); end
    rd(RegStatus, rv);
    tests++; if (rv !== 32'h3) begin fails++; $display("FAIL int_status got %h want 3", rv); end
    rd(RegCause, rv);
    tests++; if (rv !== 32'h0) begin fails++; $display("FAIL int_cause got %h want 0", rv); end
    step();
    tests++; if (jump_en !== 1'b0 || jump_addr !== 32'h0) begin
      fails++; $display("FAIL redir_one_cycle got en=%b addr=%h want 0/0", jump_en, jump_addr);
    end
    irq = 1'b0;
    idle(2);
  endtask

  task automatic test_eret();
    cp_oper = CpEret; op_valid = 1'b1;
    step();
    tests++; if (jump_en !== 1'b1 || jump_addr !== 32'h40) begin
      fails++; $display("FAIL eret_jump got en=%b addr=%h want 1/40", jump_en, jump_addr);
    end
    rd(RegStatus, rv);
    tests++; if (rv !== 32'h1) begin fails++; $display("FAIL eret_status got %h want 1", rv); end
    cp_oper = CpStore; cp_addr = RegStatus; cp_wdata = 32'h0; op_valid = 1'b1;
    step(); step(); step();
    idle_in();
    rd(RegStatus, rv);
    tests++; if (rv !== 32'h1) begin fails++; $display("FAIL settle_ignores_op got %h want 1", rv); end
  endtask

  task automatic test_ri_priority();
    irq = 1'b1;
    step();
    exc_ri = 1'b1; op_valid = 1'b1; epc_in = 32'h80;
    step();
    idle_in();
    tests++; if (jump_en !== 1'b1 || jump_addr !== 32'hC) begin
      fails++; $display("FAIL ri_jump got en=%b addr=%h want 1/c", jump_en, jump_addr);
    end
    rd(RegCause, rv);
    tests++; if (rv !== 32'h428) begin fails++; $display("FAIL ri_cause got %h want 428", rv); end
    rd(RegEpc, rv);
    tests++; if (rv !== 32'h80) begin fails++; $display("FAIL ri_epc got %h want 80", rv); end
    idle(2);
    op_valid = 1'b1;
    step();
    tests++; if (jump_en !== 1'b0) begin fails++; $display("FAIL exl_blocks_int got %b want 0", jump_en); end
    exc_ri = 1'b1; epc_in = 32'h99;
    step();
    exc_ri = 1'b0;
    tests++; if (jump_en !== 1'b0) begin fails++; $display("FAIL ri_in_exl_jump got %b want 0", jump_en); end
    rd(RegEpc, rv);
    tests++; if (rv !== 32'h80) begin fails++; $display("FAIL ri_in_exl_epc got %h want 80", rv); end
    cp_oper = CpEret;
    step();
    cp_oper = CpNone; epc_in = 32'hC0;
    tests++; if (jump_en !== 1'b1 || jump_addr !== 32'h80) begin
      fails++; $display("FAIL ri_eret got en=%b addr=%h want 1/80", jump_en, jump_addr);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if (jump_en !== 1'b0) begin fails++; $display("FAIL int_held_settle%0d got %b want 0", i, jump_en); end
    end
    step();
    idle_in();
    tests++; if (jump_en !== 1'b1 || jump_addr !== 32'hC) begin
      fails++; $display("FAIL int_after_settle got en=%b addr=%h want 1/c", jump_en, jump_addr);
    end
    rd(RegEpc, rv);
    tests++; if (rv !== 32'hC0) begin fails++; $display("FAIL int_after_settle_epc got %h want c0", rv); end
    rd(RegCause, rv);
    tests++; if (rv !== 32'h0) begin fails++; $display("FAIL int_after_settle_cause got %h want 0", rv); end
    irq = 1'b0;
    idle(3);
    eret_and_settle();
  endtask

  task automatic test_masked_irq();
    mtc0(RegStatus, 32'h0);
    irq = 1'b1; op_valid = 1'b1; epc_in = 32'h100;
    step(); step();
    tests++; if (jump_en !== 1'b0) begin fails++; $display("FAIL masked_no_jump got %b want 0", jump_en); end
    rd(RegCause, rv);
    tests++; if (rv !== 32'h400) begin fails++; $display("FAIL masked_ip got %h want 400", rv); end
    cp_oper = CpStore; cp_addr = RegStatus; cp_wdata = 32'h1;
    step();
    tests++; if (jump_en !== 1'b0) begin fails++; $display("FAIL mtc0_cycle_no_jump got %b want 0", jump_en); end
    cp_oper = CpNone;
    step();
    idle_in();
    tests++; if (jump_en !== 1'b1 || jump_addr !== 32'hC) begin
      fails++; $display("FAIL unmask_jump got en=%b addr=%h want 1/c", jump_en, jump_addr);
    end
    rd(RegEpc, rv);
    tests++; if (rv !== 32'h100) begin fails++; $display("FAIL unmask_epc got %h want 100", rv); end
    irq = 1'b0;
    idle(3);
    eret_and_settle();
  endtask

  task automatic test_reset_redir();
    mtc0(RegEbase, 32'h200);
    exc_ri = 1'b1; op_valid = 1'b1; epc_in = 32'h300;
    step();
    idle_in();
    tests++; if (jump_en !== 1'b1 || jump_addr !== 32'h200) begin
      fails++; $display("FAIL ebase_jump got en=%b addr=%h want 1/200", jump_en, jump_addr);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++; if (jump_en !== 1'b0 || jump_addr !== 32'h0) begin
      fails++; $display("FAIL rst_redir_jump got en=%b addr=%h want 0/0", jump_en, jump_addr);
    end
    rd(RegEbase, rv);
    tests++; if (rv !== 32'hC) begin fails++; $display("FAIL rst_redir_ebase got %h want c", rv); end
    rd(RegStatus, rv);
    tests++; if (rv !== 32'h0) begin fails++; $display("FAIL rst_redir_status got %h want 0", rv); end
    mtc0(RegEpc, 32'h55);
    rd(RegEpc, rv);
    tests++; if (rv !== 32'h55) begin fails++; $display("FAIL rst_then_run got %h want 55", rv); end
  endtask

  initial begin
    test_reset();
    test_mtc0();
    test_irq();
    test_eret();
    test_ri_priority();
    test_masked_irq();
    test_reset_redir();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
